preadd_sequencer: RTL and testbench

- Two-requester scheduler for the dual A/D pre-adder datapath. It runs with A_REG=1, D_REG=1, USE_DPORT="TRUE" and the direct A input.
- Arbitrates round-robin between requesters, muxes the winner's A/D operands onto the datapath, and translates a 2-bit opcode into a registered INMODE.
- Drives all clock enables and resets of the datapath.
- Tracks pipeline latency and flags the cycle in which amult carries each result, tagged with the requester id.

---
 rtl/preadd_sequencer_pkg.sv | 24 ++
 rtl/preadd_sequencer_arb.sv | 35 +++
 rtl/preadd_sequencer.sv | 124 ++++++++++++
 tb/tb_preadd_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/preadd_sequencer_pkg.sv
// Shared opcode constants and the opcode-to-INMODE translation
// for the dual A/D pre-adder scheduler.
package preadd_sequencer_pkg;

    localparam logic [1:0] OP_A   = 2'b00;
    localparam logic [1:0] OP_DPA = 2'b01;
    localparam logic [1:0] OP_DMA = 2'b10;
    localparam logic [1:0] OP_D   = 2'b11;

    // inmode[0] stays 0 so the multiplier always sees the A2 register.
    function automatic logic [3:0] op_to_inmode(input logic [1:0] op);
        logic [3:0] im;
        im = 4'b0000;
        case (op)
            OP_A:    im = 4'b0000;
            OP_DPA:  im = 4'b0100;
            OP_DMA:  im = 4'b1100;
            OP_D:    im = 4'b0110;
            default: im = 4'b0000;
        endcase
        return im;
    endfunction

endpackage

// File: rtl/preadd_sequencer_arb.sv
// Two-way round-robin arbiter; the priority pointer moves to the
// losing requester after every issue.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic advance_i,
    output logic issue_o,
    output logic win_o,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        issue_o = (req0_i | req1_i) & advance_i;
        // ptr=0: 0 wins if requesting; ptr=1: 1 wins if requesting.
        win_o   = ptr_q ? req1_i : ~req0_i;
        gnt0_o  = issue_o & ~win_o;
        gnt1_o  = issue_o & win_o;
        ptr_d   = issue_o ? ~win_o : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/preadd_sequencer.sv
// Two-requester scheduler for the A/D pre-adder datapath: arbitration,
// operand mux, INMODE register, enables and result-latency tracking.
module preadd_sequencer
    import preadd_sequencer_pkg::*;
#(
    parameter int A_WIDTH = 30,
    parameter int D_WIDTH = 25,
    parameter int AD_REG  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic [1:0]         op0,
    input  logic [A_WIDTH-1:0] a0,
    input  logic [D_WIDTH-1:0] d0,
    output logic               gnt0,
    input  logic               req1,
    input  logic [1:0]         op1,
    input  logic [A_WIDTH-1:0] a1,
    input  logic [D_WIDTH-1:0] d1,
    output logic               gnt1,
    input  logic               hold,
    input  logic               flush,
    output logic [A_WIDTH-1:0] a,
    output logic [D_WIDTH-1:0] d,
    output logic [3:0]         inmode,
    output logic               cea1,
    output logic               cea2,
    output logic               ced,
    output logic               cead,
    output logic               rsta,
    output logic               rstd,
    output logic               res_valid,
    output logic               res_tag,
    output logic               busy
);

    logic       issue;
    logic       win;
    logic       run;
    logic [3:0] inmode_q, inmode_d;
    logic       s1_valid_q, s1_valid_d;
    logic       s1_tag_q, s1_tag_d;
    logic       s2_valid_q, s2_valid_d;
    logic       s2_tag_q, s2_tag_d;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_i    (req0),
        .req1_i    (req1),
        .advance_i (~hold & ~flush),
        .issue_o   (issue),
        .win_o     (win),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1)
    );

    assign run = ~hold & ~flush;

    always_comb begin
        a        = '0;
        d        = '0;
        inmode_d = inmode_q;
        if (issue) begin
            a        = win ? a1 : a0;
            d        = win ? d1 : d0;
            inmode_d = op_to_inmode(win ? op1 : op0);
        end
    end

    // Stage advance: flush clears, hold freezes, otherwise shift by one.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_tag_d   = s2_tag_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else if (!hold) begin
            s1_valid_d = issue;
            s1_tag_d   = issue ? win : s1_tag_q;
            s2_valid_d = (AD_REG != 0) ? s1_valid_q : 1'b0;
            s2_tag_d   = (AD_REG != 0) ? s1_tag_q : s2_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inmode_q   <= 4'b0000;
            s1_valid_q <= 1'b0;
            s1_tag_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= 1'b0;
        end else begin
            inmode_q   <= inmode_d;
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    always_comb begin
        inmode = inmode_q;
        cea1   = 1'b0;
        cea2   = issue;
        ced    = issue;
        rsta   = flush;
        rstd   = flush;
        busy   = s1_valid_q | s2_valid_q;
        if (AD_REG != 0) begin
            cead      = s1_valid_q & run;
            res_valid = s2_valid_q & run;
            res_tag   = s2_tag_q;
        end else begin
            cead      = 1'b0;
            res_valid = s1_valid_q & run;
            res_tag   = s1_tag_q;
        end
    end

endmodule

// File: tb/tb_preadd_sequencer.sv
// Randomized bench for preadd_sequencer against a queue-based model of
// in-flight operations, plus directed reset and flush/hold scenarios.
module tb_preadd_sequencer;

    localparam int AW  = 30;
    localparam int DW  = 25;
    localparam int ADR = 1;
    localparam int LAT = ADR + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 0, req1 = 0, hold = 0, flush = 0;
    logic [1:0]    op0 = 0, op1 = 0;
    logic [AW-1:0] a0 = 0, a1 = 0;
    logic [DW-1:0] d0 = 0, d1 = 0;
    logic          gnt0, gnt1, cea1, cea2, ced, cead, rsta, rstd;
    logic          res_valid, res_tag, busy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    inmode;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit tag;
        int age;
    } op_t;

    op_t      inflight[$];
    bit       prio;
    bit [3:0] exp_inmode;
    bit       exp_gnt0, exp_gnt1;
    int       cyc = 0;

    preadd_sequencer #(.A_WIDTH(AW), .D_WIDTH(DW), .AD_REG(ADR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .d0(d0), .gnt0(gnt0),
        .req1(req1), .op1(op1), .a1(a1), .d1(d1), .gnt1(gnt1),
        .hold(hold), .flush(flush), .a(a), .d(d), .inmode(inmode),
        .cea1(cea1), .cea2(cea2), .ced(ced), .cead(cead),
        .rsta(rsta), .rstd(rstd), .res_valid(res_valid),
        .res_tag(res_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit [3:0] ref_inmode(input bit [1:0] op);
        bit [3:0] tbl [4] = '{4'b0000, 4'b0100, 4'b1100, 4'b0110};
        return tbl[op];
    endfunction

    function automatic bit has_age(input int age);
        foreach (inflight[i]) if (inflight[i].age == age) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit tag_at(input int age);
        foreach (inflight[i]) if (inflight[i].age == age) return inflight[i].tag;
        return 1'b0;
    endfunction

    task automatic model_reset();
        inflight.delete();
        prio       = 1'b0;
        exp_inmode = 4'b0000;
    endtask

    // One cycle: drive inputs on negedge, check outputs, update model at posedge.
    task automatic step(input bit r0, input bit [1:0] o0, input bit [AW-1:0] va0,
                        input bit [DW-1:0] vd0, input bit r1, input bit [1:0] o1,
                        input bit [AW-1:0] va1, input bit [DW-1:0] vd1,
                        input bit h, input bit f);
        bit iss, w, run, rv;
        @(negedge clk);
        req0 = r0; op0 = o0; a0 = va0; d0 = vd0;
        req1 = r1; op1 = o1; a1 = va1; d1 = vd1;
        hold = h; flush = f;
        #1;
        run = !h && !f;
        iss = (r0 || r1) && run;
        w   = prio ? r1 : !r0;
        exp_gnt0 = iss && !w;
        exp_gnt1 = iss && w;
        rv  = has_age(LAT) && run;
        check_val("gnt0", gnt0, exp_gnt0);
        check_val("gnt1", gnt1, exp_gnt1);
        check_val("a", a, iss ? (w ? va1 : va0) : 0);
        check_val("d", d, iss ? (w ? vd1 : vd0) : 0);
        check_val("inmode", inmode, exp_inmode);
        check_val("cea1", cea1, 0);
        check_val("cea2", cea2, iss);
        check_val("ced", ced, iss);
        check_val("cead", cead, (ADR != 0) && has_age(1) && run);
        check_val("rsta", rsta, f);
        check_val("rstd", rstd, f);
        check_val("res_valid", res_valid, rv);
        if (rv) check_val("res_tag", res_tag, tag_at(LAT));
        check_val("busy", busy, inflight.size() != 0);
        if (iss) $display("cyc=%0d issue tag=%0d op=%0d", cyc, w, w ? o1 : o0);
        if (rv) $display("cyc=%0d result tag=%0d", cyc, tag_at(LAT));
        @(posedge clk);
        cyc++;
        if (f) begin
            inflight.delete();
        end else if (!h) begin
            foreach (inflight[i]) inflight[i].age++;
            while (inflight.size() != 0 && inflight[0].age > LAT) void'(inflight.pop_front());
            if (iss) begin
                inflight.push_back('{tag: w, age: 1});
                exp_inmode = ref_inmode(w ? o1 : o0);
                prio = !w;
            end
        end
    endtask

    task automatic idle(input bit h, input bit f);
        step(0, 0, 0, 0, 0, 0, 0, 0, h, f);
    endtask

    initial begin
        bit          r0, r1, h, f;
        bit [1:0]    o0, o1;
        bit [AW-1:0] va0, va1;
        bit [DW-1:0] vd0, vd1;

        model_reset();
        #12;
        check_val("rst_inmode", inmode, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_cead", cead, 0);
        rst_n = 1'b1;

        // Single op, D+A, then drain.
        step(1, 2'b01, 5, 7, 0, 0, 0, 0, 0, 0);
        repeat (3) idle(0, 0);
        // Both requesting: alternating grants.
        repeat (4) step(1, 2'b00, 11, 12, 1, 2'b11, 21, 22, 0, 0);
        repeat (3) idle(0, 0);
        // Op 11 then op 10 back-to-back.
        step(1, 2'b11, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 2'b10, 3, 4, 0, 0);
        repeat (3) idle(0, 0);
        // Hold for 3 cycles with an op in flight and a pending request.
        step(1, 2'b01, 9, 9, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 2'b01, 8, 8, 1, 0);
        repeat (3) idle(0, 0);
        // Flush with op in flight, then flush together with hold.
        step(1, 2'b10, 6, 6, 0, 0, 0, 0, 0, 0);
        idle(0, 1);
        idle(0, 0);
        step(0, 0, 0, 0, 1, 2'b11, 4, 4, 0, 0);
        step(1, 2'b01, 3, 3, 1, 2'b01, 3, 3, 1, 1);
        repeat (2) idle(0, 0);

        // Random traffic; requesters hold their operands until granted.
        r0 = 0; r1 = 0; o0 = 0; o1 = 0; va0 = 0; va1 = 0; vd0 = 0; vd1 = 0;
        for (int n = 0; n < 600; n++) begin
            if (!(r0 && !exp_gnt0)) begin
                r0 = ($urandom_range(0, 3) != 0);
                o0 = 2'($urandom); va0 = AW'($urandom); vd0 = DW'($urandom);
            end
            if (!(r1 && !exp_gnt1)) begin
                r1 = ($urandom_range(0, 3) != 0);
                o1 = 2'($urandom); va1 = AW'($urandom); vd1 = DW'($urandom);
            end
            h = ($urandom_range(0, 99) < 15);
            f = ($urandom_range(0, 99) < 7);
            step(r0, o0, va0, vd0, r1, o1, va1, vd1, h, f);

            if (n == 300) begin
                // Asynchronous reset in mid-burst.
                @(negedge clk);
                req0 = 1; req1 = 1; hold = 0; flush = 0;
                #2 rst_n = 1'b0;
                #1;
                check_val("arst_inmode", inmode, 0);
                check_val("arst_res_valid", res_valid, 0);
                check_val("arst_busy", busy, 0);
                check_val("arst_cead", cead, 0);
                model_reset();
                @(posedge clk);
                #2 rst_n = 1'b1;
                step(1, 2'b01, 1, 1, 1, 2'b10, 2, 2, 0, 0);
                check_val("arst_first_gnt0", exp_gnt0 && gnt0 === 1'b1, 1);
                r0 = 0; r1 = 0;
            end
        end
        repeat (3) idle(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
